// File: rtl/trace_dispatch_pkg.sv
// Shared definitions for the trace dispatcher: cache geometry, trace op codes and FSM states.
package trace_dispatch_pkg;

    localparam int ADDR_SIZE  = 32;
    localparam int NUM_SETS   = 16;
    localparam int INDEX_SIZE = $clog2(NUM_SETS);

    typedef enum logic [3:0] {
        OP_READ       = 4'd0,
        OP_WRITE      = 4'd1,
        OP_IFETCH     = 4'd2,
        OP_SNOOP_RD   = 4'd3,
        OP_SNOOP_WR   = 4'd4,
        OP_SNOOP_RWIM = 4'd5,
        OP_INVAL      = 4'd6,
        OP_RSVD7      = 4'd7,
        OP_CLEAR      = 4'd8,
        OP_PRINT      = 4'd9
    } trace_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_CLEAR = 2'd3
    } dispatch_state_e;

    function automatic logic is_read_op(input logic [3:0] op);
        return (op == OP_READ) || (op == OP_IFETCH);
    endfunction

endpackage

// File: rtl/stat_counter.sv
// Saturating statistics counter with synchronous clear (clear wins over increment).
module stat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/trace_dispatch.sv
// Trace command dispatcher: turns trace ops into one-cycle cache strobes and keeps hit/miss stats.
// Statistics counters exist only when LLC_STATS_EN is defined; otherwise the stat outputs are 0.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready for a command (cmd_ready=1)
// ST_ISSUE | one cycle, the registered strobe for the accepted op is high
// ST_WAIT  | waiting for cache_done, abandoned after TIMEOUT_CYCLES cycles
// ST_CLEAR | sweeping clear_req over every set index
module trace_dispatch
    import trace_dispatch_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int STAT_W         = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    input  logic [3:0]            cmd_op,
    input  logic [ADDR_SIZE-1:0]  cmd_addr,
    output logic                  cmd_ready,
    output logic [ADDR_SIZE-1:0]  address,
    output logic                  read_req,
    output logic                  write_req,
    output logic                  invalidate,
    output logic                  snoop_req,
    output logic [1:0]            snoop_op,
    output logic                  clear_req,
    output logic [INDEX_SIZE-1:0] clear_index,
    output logic                  print_req,
    input  logic                  cache_done,
    input  logic                  cache_hit,
    output logic                  bad_op,
    output logic                  timeout_err,
    output logic [STAT_W-1:0]     stat_reads,
    output logic [STAT_W-1:0]     stat_writes,
    output logic [STAT_W-1:0]     stat_hits,
    output logic [STAT_W-1:0]     stat_misses
);

    localparam int WCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    dispatch_state_e       state_q, state_d;
    logic [3:0]            op_q, op_d;
    logic [ADDR_SIZE-1:0]  address_q, address_d;
    logic [WCNT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic [INDEX_SIZE-1:0] clear_index_q, clear_index_d;
    logic [1:0]            snoop_op_q, snoop_op_d;
    logic                  read_req_q, read_req_d;
    logic                  write_req_q, write_req_d;
    logic                  invalidate_q, invalidate_d;
    logic                  snoop_req_q, snoop_req_d;
    logic                  clear_req_q, clear_req_d;
    logic                  print_req_q, print_req_d;
    logic                  bad_op_q, bad_op_d;
    logic                  timeout_err_q, timeout_err_d;
    logic                  wait_done;
    logic                  stat_clr;

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        address_d     = address_q;
        wait_cnt_d    = wait_cnt_q;
        clear_index_d = '0;
        snoop_op_d    = snoop_op_q;
        read_req_d    = 1'b0;
        write_req_d   = 1'b0;
        invalidate_d  = 1'b0;
        snoop_req_d   = 1'b0;
        clear_req_d   = 1'b0;
        print_req_d   = 1'b0;
        bad_op_d      = 1'b0;
        timeout_err_d = 1'b0;
        wait_done     = 1'b0;
        stat_clr      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    address_d = cmd_addr;
                    op_d      = cmd_op;
                    if (cmd_op == OP_CLEAR) begin
                        state_d     = ST_CLEAR;
                        clear_req_d = 1'b1;
                    end else begin
                        // Strobes are registered here so they are high during ISSUE.
                        state_d = ST_ISSUE;
                        case (cmd_op)
                            OP_READ, OP_IFETCH: read_req_d = 1'b1;
                            OP_WRITE:           write_req_d = 1'b1;
                            OP_SNOOP_RD, OP_SNOOP_WR, OP_SNOOP_RWIM: begin
                                snoop_req_d = 1'b1;
                                snoop_op_d  = 2'(cmd_op - 4'(OP_SNOOP_RD));
                            end
                            OP_INVAL:           invalidate_d = 1'b1;
                            OP_PRINT:           print_req_d = 1'b1;
                            default:            bad_op_d = 1'b1;
                        endcase
                    end
                end
            end
            ST_ISSUE: begin
                wait_cnt_d = '0;
                if (op_q <= 4'(OP_INVAL)) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cache_done) begin
                    wait_done = 1'b1;
                    state_d   = ST_IDLE;
                end else if (wait_cnt_q == WCNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                end
            end
            ST_CLEAR: begin
                stat_clr = (clear_index_q == '0);
                if (clear_index_q == INDEX_SIZE'(NUM_SETS - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    clear_req_d   = 1'b1;
                    clear_index_d = clear_index_q + INDEX_SIZE'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            op_q          <= '0;
            address_q     <= '0;
            wait_cnt_q    <= '0;
            clear_index_q <= '0;
            snoop_op_q    <= '0;
            read_req_q    <= 1'b0;
            write_req_q   <= 1'b0;
            invalidate_q  <= 1'b0;
            snoop_req_q   <= 1'b0;
            clear_req_q   <= 1'b0;
            print_req_q   <= 1'b0;
            bad_op_q      <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            address_q     <= address_d;
            wait_cnt_q    <= wait_cnt_d;
            clear_index_q <= clear_index_d;
            snoop_op_q    <= snoop_op_d;
            read_req_q    <= read_req_d;
            write_req_q   <= write_req_d;
            invalidate_q  <= invalidate_d;
            snoop_req_q   <= snoop_req_d;
            clear_req_q   <= clear_req_d;
            print_req_q   <= print_req_d;
            bad_op_q      <= bad_op_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign address     = address_q;
    assign read_req    = read_req_q;
    assign write_req   = write_req_q;
    assign invalidate  = invalidate_q;
    assign snoop_req   = snoop_req_q;
    assign snoop_op    = snoop_op_q;
    assign clear_req   = clear_req_q;
    assign clear_index = clear_index_q;
    assign print_req   = print_req_q;
    assign bad_op      = bad_op_q;
    assign timeout_err = timeout_err_q;

`ifdef LLC_STATS_EN
    logic data_op;
    logic inc_reads, inc_writes, inc_hits, inc_misses;

    // Only demand accesses (read, write, ifetch) count toward hit/miss.
    assign data_op    = (op_q <= 4'(OP_IFETCH));
    assign inc_reads  = wait_done && is_read_op(op_q);
    assign inc_writes = wait_done && (op_q == OP_WRITE);
    assign inc_hits   = wait_done && data_op && cache_hit;
    assign inc_misses = wait_done && data_op && !cache_hit;

    stat_counter #(.W(STAT_W)) u_stat_reads (
        .clk(clk), .rst(rst), .clr_i(stat_clr), .inc_i(inc_reads), .count_o(stat_reads)
    );
    stat_counter #(.W(STAT_W)) u_stat_writes (
        .clk(clk), .rst(rst), .clr_i(stat_clr), .inc_i(inc_writes), .count_o(stat_writes)
    );
    stat_counter #(.W(STAT_W)) u_stat_hits (
        .clk(clk), .rst(rst), .clr_i(stat_clr), .inc_i(inc_hits), .count_o(stat_hits)
    );
    stat_counter #(.W(STAT_W)) u_stat_misses (
        .clk(clk), .rst(rst), .clr_i(stat_clr), .inc_i(inc_misses), .count_o(stat_misses)
    );
`else
    logic stats_unused;

    assign stats_unused = ^{cache_hit, wait_done, stat_clr};
    assign stat_reads   = '0;
    assign stat_writes  = '0;
    assign stat_hits    = '0;
    assign stat_misses  = '0;
`endif

endmodule

// File: tb/tb_trace_dispatch.sv
// Self-checking bench for trace_dispatch: directed scenarios plus randomized ops against a reference model.
module tb_trace_dispatch;
    import trace_dispatch_pkg::*;

    localparam int TIMEOUT = 64;
    localparam int SW      = 4;
    localparam int MAXV    = (1 << SW) - 1;
`ifdef LLC_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  cmd_valid = 1'b0;
    logic [3:0]            cmd_op = '0;
    logic [ADDR_SIZE-1:0]  cmd_addr = '0;
    logic                  cmd_ready;
    logic [ADDR_SIZE-1:0]  address;
    logic                  read_req, write_req, invalidate, snoop_req;
    logic [1:0]            snoop_op;
    logic                  clear_req;
    logic [INDEX_SIZE-1:0] clear_index;
    logic                  print_req;
    logic                  cache_done = 1'b0;
    logic                  cache_hit = 1'b0;
    logic                  bad_op, timeout_err;
    logic [SW-1:0]         stat_reads, stat_writes, stat_hits, stat_misses;

    int errors = 0;
    int checks = 0;
    int m_reads = 0, m_writes = 0, m_hits = 0, m_misses = 0;

    always #5 clk = ~clk;

    trace_dispatch #(.TIMEOUT_CYCLES(TIMEOUT), .STAT_W(SW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_ready(cmd_ready),
        .address(address), .read_req(read_req), .write_req(write_req), .invalidate(invalidate),
        .snoop_req(snoop_req), .snoop_op(snoop_op), .clear_req(clear_req), .clear_index(clear_index),
        .print_req(print_req), .cache_done(cache_done), .cache_hit(cache_hit),
        .bad_op(bad_op), .timeout_err(timeout_err),
        .stat_reads(stat_reads), .stat_writes(stat_writes),
        .stat_hits(stat_hits), .stat_misses(stat_misses)
    );

    // Bit order: read, write, snoop, inval, print, bad, clear, timeout.
    function automatic logic [7:0] exp_strobes(input int op);
        case (op)
            0, 2:    return 8'b1000_0000;
            1:       return 8'b0100_0000;
            3, 4, 5: return 8'b0010_0000;
            6:       return 8'b0001_0000;
            9:       return 8'b0000_1000;
            8:       return 8'b0000_0010;
            default: return 8'b0000_0100;
        endcase
    endfunction

    function automatic logic [7:0] obs_strobes();
        return {read_req, write_req, snoop_req, invalidate, print_req, bad_op, clear_req, timeout_err};
    endfunction

    function automatic logic [4*SW-1:0] exp_stats();
        if (!STATS_ON) return '0;
        return {SW'(m_reads), SW'(m_writes), SW'(m_hits), SW'(m_misses)};
    endfunction

    function automatic logic [4*SW-1:0] obs_stats();
        return {stat_reads, stat_writes, stat_hits, stat_misses};
    endfunction

    function automatic int sat_inc(input int v);
        return (v < MAXV) ? v + 1 : v;
    endfunction

    // Drives one command from IDLE and checks it all the way back to IDLE.
    task automatic do_cmd(input logic [3:0] op, input logic [31:0] addr, input int dly,
                          input logic hit, input string tag);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL %s ready_before: got %b expected 1", tag, cmd_ready);
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 4'($urandom); cmd_addr = $urandom;
        if (op == 4'd8) begin
            for (int i = 0; i < NUM_SETS; i++) begin
                checks++;
                if (clear_req !== 1'b1 || clear_index !== INDEX_SIZE'(i) || cmd_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s clear_step%0d: got req=%b idx=%0d rdy=%b expected req=1 idx=%0d rdy=0",
                             tag, i, clear_req, clear_index, cmd_ready, i);
                end
                @(negedge clk);
            end
            m_reads = 0; m_writes = 0; m_hits = 0; m_misses = 0;
        end else begin
            checks++;
            if (obs_strobes() !== exp_strobes(op) || address !== addr || cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s issue: got strobes=%b addr=%h rdy=%b expected strobes=%b addr=%h rdy=0",
                         tag, obs_strobes(), address, cmd_ready, exp_strobes(op), addr);
            end
            if (op >= 4'd3 && op <= 4'd5) begin
                checks++;
                if (snoop_op !== 2'(op - 4'd3)) begin
                    errors++; $display("FAIL %s snoop_op: got %0d expected %0d", tag, snoop_op, op - 4'd3);
                end
            end
            // A done during ISSUE must be ignored.
            cache_done = 1'($urandom_range(0, 1)); cache_hit = 1'($urandom);
            @(negedge clk);
            cache_done = 1'b0;
            if (op <= 4'd6) begin
                repeat (dly - 1) @(negedge clk);
                checks++;
                if (obs_strobes() !== 8'h00 || cmd_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s wait: got strobes=%b rdy=%b expected strobes=00000000 rdy=0",
                             tag, obs_strobes(), cmd_ready);
                end
                cache_done = 1'b1; cache_hit = hit;
                @(negedge clk);
                cache_done = 1'b0; cache_hit = 1'($urandom);
                if (op == 4'd0 || op == 4'd2) m_reads = sat_inc(m_reads);
                if (op == 4'd1) m_writes = sat_inc(m_writes);
                if (op <= 4'd2) begin
                    if (hit) m_hits = sat_inc(m_hits);
                    else     m_misses = sat_inc(m_misses);
                end
            end
        end
        checks++;
        if (cmd_ready !== 1'b1 || obs_strobes() !== 8'h00 || obs_stats() !== exp_stats()) begin
            errors++;
            $display("FAIL %s end: got rdy=%b strobes=%b stats=%h expected rdy=1 strobes=00000000 stats=%h",
                     tag, cmd_ready, obs_strobes(), obs_stats(), exp_stats());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (obs_strobes() !== 8'h00 || address !== '0 || clear_index !== '0 || snoop_op !== 2'd0 ||
            obs_stats() !== '0) begin
            errors++;
            $display("FAIL reset_values: got strobes=%b addr=%h idx=%0d sop=%0d stats=%h expected all 0",
                     obs_strobes(), address, clear_index, snoop_op, obs_stats());
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_read_hit();
        do_cmd(4'd0, 32'h0000_1040, 3, 1'b1, "read_hit");
    endtask

    task automatic test_write_miss();
        do_cmd(4'd1, 32'h0000_2080, 2, 1'b0, "write_miss");
    endtask

    task automatic test_snoop();
        do_cmd(4'd3, 32'h0000_3000, 1, 1'b1, "snoop_rd");
        do_cmd(4'd5, 32'h0000_30C0, 4, 1'b1, "snoop_rwim");
        do_cmd(4'd6, 32'h0000_4000, 2, 1'b0, "inval");
        do_cmd(4'd9, 32'h0000_5000, 1, 1'b0, "print");
    endtask

    task automatic test_bad_ops();
        do_cmd(4'd7, 32'h0000_7000, 1, 1'b0, "bad_op7");
        do_cmd(4'd12, 32'h0000_C000, 1, 1'b0, "bad_op12");
    endtask

    task automatic test_clear();
        do_cmd(4'd2, 32'h0000_0100, 2, 1'b1, "pre_clear_read");
        do_cmd(4'd8, 32'h0, 1, 1'b0, "clear");
    endtask

    task automatic test_ignored_done();
        cache_done = 1'b1; cache_hit = 1'b1;
        repeat (3) @(negedge clk);
        cache_done = 1'b0;
        checks++;
        if (cmd_ready !== 1'b1 || obs_stats() !== exp_stats() || obs_strobes() !== 8'h00) begin
            errors++;
            $display("FAIL idle_done: got rdy=%b stats=%h strobes=%b expected rdy=1 stats=%h strobes=0",
                     cmd_ready, obs_stats(), obs_strobes(), exp_stats());
        end
    endtask

    task automatic test_timeout();
        int n;
        cmd_valid = 1'b1; cmd_op = 4'd0; cmd_addr = 32'h0000_0ABC;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (timeout_err !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != TIMEOUT + 1) begin
            errors++; $display("FAIL timeout_latency: got %0d cycles after issue expected %0d", n, TIMEOUT + 1);
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL timeout_idle: got rdy=%b expected 1", cmd_ready);
        end
        @(negedge clk);
        checks++;
        if (timeout_err !== 1'b0 || obs_stats() !== exp_stats()) begin
            errors++;
            $display("FAIL timeout_after: got terr=%b stats=%h expected terr=0 stats=%h",
                     timeout_err, obs_stats(), exp_stats());
        end
        do_cmd(4'd0, 32'h0000_0DEF, TIMEOUT, 1'b0, "done_at_limit");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_cmd(4'($urandom_range(0, 15)), $urandom, $urandom_range(1, 12), 1'($urandom), "random");
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < MAXV + 3; i++) do_cmd(4'd0, $urandom, 1, 1'b1, "sat_read");
        for (int i = 0; i < MAXV + 3; i++) do_cmd(4'd1, $urandom, 1, 1'b0, "sat_write");
    endtask

    task automatic test_reset_mid_clear();
        int n;
        cmd_valid = 1'b1; cmd_op = 4'd8;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (clear_index !== INDEX_SIZE'(5) && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (clear_req !== 1'b1 || clear_index !== INDEX_SIZE'(5)) begin
            errors++; $display("FAIL clear_reach5: got req=%b idx=%0d expected req=1 idx=5", clear_req, clear_index);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (clear_req !== 1'b0 || clear_index !== '0) begin
            errors++; $display("FAIL rst_clear_async: got req=%b idx=%0d expected 0 0", clear_req, clear_index);
        end
        m_reads = 0; m_writes = 0; m_hits = 0; m_misses = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || clear_index !== '0 || obs_strobes() !== 8'h00) begin
            errors++;
            $display("FAIL rst_clear_after: got rdy=%b idx=%0d strobes=%b expected 1 0 0",
                     cmd_ready, clear_index, obs_strobes());
        end
    endtask

    task automatic test_reset_mid_wait();
        logic bad;
        do_cmd(4'd0, 32'h0000_1111, 1, 1'b1, "pre_wait_read");
        cmd_valid = 1'b1; cmd_op = 4'd1; cmd_addr = 32'h0000_2222;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        m_reads = 0; m_writes = 0; m_hits = 0; m_misses = 0;
        @(negedge clk);
        rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < TIMEOUT + 10; i++) begin
            @(negedge clk);
            if (obs_strobes() !== 8'h00 || cmd_ready !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad || obs_stats() !== exp_stats()) begin
            errors++;
            $display("FAIL rst_wait: got late_activity=%b stats=%h expected 0 stats=%h", bad, obs_stats(), exp_stats());
        end
    endtask

    initial begin
        test_reset();
        test_read_hit();
        test_write_miss();
        test_snoop();
        test_bad_ops();
        test_clear();
        test_ignored_done();
        test_timeout();
        test_random();
        test_saturation();
        test_clear();
        test_reset_mid_clear();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/trace_dispatch.md
TRACE_DISPATCH -- requirements
Module: trace_dispatch

Interface
REQ-001 Param TIMEOUT_CYCLES, default 64: maximum WAIT cycles before a request is abandoned.
REQ-002 Param STAT_W, default 32: width of each statistics counter.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  trace command present.
REQ-006 cmd_op  input  4  trace operation code n (0..15).
REQ-007 cmd_addr  input  ADDR_SIZE  trace address.
REQ-008 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-009 address  output  ADDR_SIZE  registered address to cache.
REQ-010 read_req / write_req / invalidate  output  1 each  one-cycle cache strobes.
REQ-011 snoop_req  output  1; snoop_op  output  2  snoop strobe, 0=read, 1=write, 2=RWIM.
REQ-012 clear_req  output  1; clear_index  output  INDEX_SIZE  per-set clear strobe and set index.
REQ-013 print_req  output  1  one-cycle print strobe.
REQ-014 cache_done  input  1; cache_hit  input  1  cache completion; hit is valid only with done.
REQ-015 bad_op / timeout_err  output  1 each  one-cycle error pulses.
REQ-016 stat_reads, stat_writes, stat_hits, stat_misses  output  STAT_W each.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, CLEAR; cmd_ready SHALL be 1 only in IDLE.
REQ-018 On accept, address is registered; the FSM goes to ISSUE, except op 8, which goes to CLEAR.
REQ-019 ISSUE holds for exactly one cycle and drives one strobe:
- op 0/2: read_req
- op 1: write_req
- op 3/4/5: snoop_req with snoop_op=op-3
- op 6: invalidate
- op 9: print_req
- op 7 or 10..15: bad_op, no cache strobe
REQ-020 After ISSUE, ops 0..6 go to WAIT; ops 9, 7 and 10..15 go to IDLE.
REQ-021 Latency: the strobe is asserted in the cycle after acceptance; two back-to-back accepts are never possible.
REQ-022 WAIT: on cache_done go to IDLE; cache_done in any other state is ignored.
REQ-023 WAIT timeout:
- the wait counter starts at 0 on WAIT entry;
- if it reaches TIMEOUT_CYCLES-1 without cache_done, pulse timeout_err and go to IDLE with no statistics update.
REQ-024 CLEAR:
- clear_req=1 for NUM_SETS consecutive cycles;
- clear_index runs 0..NUM_SETS-1;
- the FSM goes to IDLE after the last index;
- all statistics are zeroed in the first CLEAR cycle.
REQ-025 Statistics on cache_done in WAIT:
- ops 0/2 increment stat_reads; op 1 increments stat_writes;
- ops 0..2 increment stat_hits if cache_hit, else stat_misses;
- snoops and invalidate leave all statistics unchanged.
REQ-026 Statistics counters saturate at 2^STAT_W-1 and never wrap.
REQ-027 All strobes and error pulses are registered outputs, 0 outside their single active cycle.

Reset
REQ-028 rst forces IDLE; all strobes, pulses, counters, clear_index, address, snoop_op and statistics go to 0; cmd_ready is 1 after reset.
REQ-029 rst during CLEAR or WAIT aborts the operation immediately; no pending strobe is emitted after release.

Configuration
REQ-030 Macro LLC_STATS_EN:
- defined: the statistics counters of REQ-025/026 are present.
- undefined: the four stat outputs are tied to 0, with no counter logic; FSM behaviour is unchanged.

Structure
REQ-031 The shared line package holds ADDR_SIZE, INDEX_SIZE, NUM_SETS, the trace-op enum (op codes 0..9) and the dispatch state enum.
REQ-032 One sub-module, stat_counter (saturating, synchronous clear, increment enable), instantiated four times under LLC_STATS_EN.

Verification
REQ-033 Reset released, cmd op0 addr 0x0000_1040, cache_done+hit after 3 cycles -> read_req 1 cycle after accept, address 0x1040, stat_reads=1, stat_hits=1.
REQ-034 op1 then cache_done with hit=0 -> write_req pulse; stat_writes=1, stat_misses=1; cmd_ready low from accept until the cycle after done.
REQ-035 op5 -> snoop_req with snoop_op=2; on done, statistics unchanged.
REQ-036 op8 after prior statistics -> clear_req high exactly NUM_SETS cycles, clear_index 0..NUM_SETS-1, statistics 0, then cmd_ready=1.
REQ-037 op7 and op12 -> bad_op pulses, no cache strobes; op0 with no cache_done -> timeout_err 64 cycles into WAIT, then IDLE.
REQ-038 rst asserted mid-CLEAR at index 5 -> clear_req=0 immediately; after release, IDLE with clear_index=0.
